// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pipe_hazard_ctrl                                              |
// | Brief    : Stall/flush scheduler and PC redirect control for the 5-stage |
// |            LC-3b pipeline, with saturating stall/flush statistics.       |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module pipe_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       id_sr1,
  input  logic [2:0]       id_sr2,
  input  logic             id_sr2mux_sel,
  input  logic             id_uses_sr1,
  input  logic             id_uses_sr2,
  input  logic             ex_is_load,
  input  logic [2:0]       ex_dr,
  input  logic             imem_read,
  input  logic             imem_resp,
  input  logic             dmem_req,
  input  logic             dmem_resp,
  input  logic             br_taken,
  input  logic [15:0]      br_target,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_ex,
  output logic             stall_mem,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             flush_ex_mem,
  output logic             pc_redirect,
  output logic [15:0]      redirect_pc,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_RPEND = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

  state_t           r_state;
  state_t           w_next_state;
  logic [15:0]      r_tgt;
  logic             w_tgt_load;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic             w_dstall;
  logic             w_istall;
  logic             w_lu;

  assign w_dstall = dmem_req & ~dmem_resp;
  assign w_istall = imem_read & ~imem_resp;
  assign w_lu     = ex_is_load &
                    ((id_uses_sr1 & (ex_dr == id_sr1)) |
                     (id_uses_sr2 & ~id_sr2mux_sel & (ex_dr == id_sr2)));

  always_comb begin
    w_next_state = r_state;
    w_tgt_load   = 1'b0;
    stall_if     = 1'b0;
    stall_id     = 1'b0;
    stall_ex     = 1'b0;
    stall_mem    = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    flush_ex_mem = 1'b0;
    pc_redirect  = 1'b0;
    redirect_pc  = br_target;
    case (r_state)
      ST_RUN: begin
        if (w_dstall) begin
          stall_if  = 1'b1;
          stall_id  = 1'b1;
          stall_ex  = 1'b1;
          stall_mem = 1'b1;
        end else if (br_taken && !w_istall) begin
          pc_redirect  = 1'b1;
          flush_if_id  = 1'b1;
          flush_id_ex  = 1'b1;
          flush_ex_mem = 1'b1;
        end else if (br_taken) begin
          // Let the outstanding fetch finish; its result is discarded in RPEND.
          stall_if     = 1'b1;
          flush_id_ex  = 1'b1;
          flush_ex_mem = 1'b1;
          w_tgt_load   = 1'b1;
          w_next_state = ST_RPEND;
        end else if (w_istall) begin
          stall_if    = 1'b1;
          flush_if_id = 1'b1;
        end else if (w_lu) begin
          stall_if    = 1'b1;
          stall_id    = 1'b1;
          flush_id_ex = 1'b1;
        end
      end
      ST_RPEND: begin
        redirect_pc = r_tgt;
        flush_if_id = 1'b1;
        if (imem_resp) begin
          pc_redirect  = 1'b1;
          w_next_state = ST_RUN;
        end else begin
          stall_if = 1'b1;
        end
      end
      default: w_next_state = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_RUN;
      r_tgt       <= 16'h0000;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_tgt_load) r_tgt <= br_target;
      if (stall_if && (r_stall_cnt != c_CNT_MAX)) r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
      if (pc_redirect && (r_flush_cnt != c_CNT_MAX)) r_flush_cnt <= r_flush_cnt + c_CNT_ONE;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule
`default_nettype wire
